// File: rtl/mem_model_axi_burst.sv
// Behavioural AXI4 slave memory: FIXED/INCR/WRAP bursts, byte strobes,
// SLVERR on bad bursts/beats, one outstanding burst per direction.
module mem_model_axi_burst #(
  parameter int          DATA_W       = 32,
  parameter int          ADDR_W       = 32,
  parameter int          ID_W         = 4,
  parameter int unsigned DEPTH        = 32'h00100000,
  parameter int          READ_LATENCY = 2
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);

  localparam int BYTES = DATA_W / 8;
  localparam int SZ    = $clog2(BYTES);
  localparam int WA    = ADDR_W - SZ;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wst_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rst_t;

  logic [DATA_W-1:0] r_mem [DEPTH];

  function automatic logic [WA-1:0] f_next(
    input logic [WA-1:0] a,
    input logic [7:0]    len,
    input logic [1:0]    burst
  );
    logic [WA-1:0] m;
    m = WA'(len);
    case (burst)
      2'd0:    return a;
      2'd2:    return (a & ~m) | ((a + WA'(1)) & m);
      default: return a + WA'(1);
    endcase
  endfunction

  function automatic logic f_bad(
    input logic [2:0] size,
    input logic [1:0] burst,
    input logic [7:0] len
  );
    logic pow2;
    pow2 = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (size != 3'(SZ)) || (burst == 2'd3) || (burst == 2'd2 && !pow2);
  endfunction

  function automatic logic f_oob(input logic [WA-1:0] a);
    return 64'(a) >= 64'(DEPTH);
  endfunction

  logic w_unused;
  assign w_unused = ^{awaddr[SZ-1:0], araddr[SZ-1:0]};

  // Write path
  wst_t            r_wst;
  logic            r_awready, r_wready, r_bvalid;
  logic [ID_W-1:0] r_bid;
  logic [1:0]      r_bresp;
  logic [WA-1:0]   r_waddr;
  logic [7:0]      r_wlen, r_wcnt;
  logic [1:0]      r_wburst;
  logic            r_wbad, r_werr;
  logic            w_whs, w_wgood, w_wfinal, w_werr;

  assign w_whs    = r_wready & wvalid;
  assign w_wgood  = !r_wbad && !f_oob(r_waddr);
  assign w_wfinal = (r_wcnt == r_wlen);
  assign w_werr   = r_werr | !w_wgood | (wlast != w_wfinal);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wst     <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= 2'b00;
      r_waddr   <= '0;
      r_wlen    <= '0;
      r_wcnt    <= '0;
      r_wburst  <= '0;
      r_wbad    <= 1'b0;
      r_werr    <= 1'b0;
    end else begin
      case (r_wst)
        W_IDLE: begin
          r_awready <= 1'b1;
          if (awvalid && r_awready) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_bid     <= awid;
            r_waddr   <= awaddr[ADDR_W-1:SZ];
            r_wlen    <= awlen;
            r_wburst  <= awburst;
            r_wbad    <= f_bad(awsize, awburst, awlen);
            r_wcnt    <= '0;
            r_werr    <= 1'b0;
            r_wst     <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_whs) begin
            r_werr  <= w_werr;
            r_waddr <= f_next(r_waddr, r_wlen, r_wburst);
            r_wcnt  <= r_wcnt + 8'd1;
            // The beat counter, not wlast, closes the burst
            if (w_wfinal) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= w_werr ? 2'b10 : 2'b00;
              r_wst    <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wst     <= W_IDLE;
          end
        end
        default: r_wst <= W_IDLE;
      endcase
    end
  end

  // Storage survives reset; wready is low while areset is held
  always_ff @(posedge aclk) begin
    if (w_whs && w_wgood) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wstrb[i]) r_mem[r_waddr[IW-1:0]][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Read path
  rst_t              r_rst;
  logic              r_arready, r_rvalid, r_rlast;
  logic [ID_W-1:0]   r_rid;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_rresp, r_rburst;
  logic [WA-1:0]     r_raddr;
  logic [7:0]        r_rlen, r_rcnt;
  logic              r_rbad;
  logic [3:0]        r_lat;
  logic              w_rgood;
  logic [DATA_W-1:0] w_ld_data;

  assign w_rgood   = !r_rbad && !f_oob(r_raddr);
  assign w_ld_data = w_rgood ? r_mem[r_raddr[IW-1:0]] : '0;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_rst     <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= '0;
      r_rdata   <= '0;
      r_rresp   <= 2'b00;
      r_rburst  <= '0;
      r_raddr   <= '0;
      r_rlen    <= '0;
      r_rcnt    <= '0;
      r_rbad    <= 1'b0;
      r_lat     <= '0;
    end else begin
      case (r_rst)
        R_IDLE: begin
          r_arready <= 1'b1;
          if (arvalid && r_arready) begin
            r_arready <= 1'b0;
            r_rid     <= arid;
            r_raddr   <= araddr[ADDR_W-1:SZ];
            r_rlen    <= arlen;
            r_rburst  <= arburst;
            r_rbad    <= f_bad(arsize, arburst, arlen);
            r_rcnt    <= '0;
            r_lat     <= 4'(READ_LATENCY);
            r_rst     <= R_WAIT;
          end
        end
        R_WAIT, R_DATA: begin
          if (r_rst == R_DATA && rready && r_rlast) begin
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_arready <= 1'b1;
            r_rst     <= R_IDLE;
          end else if ((r_rst == R_WAIT && r_lat == 4'd0) ||
                       (r_rst == R_DATA && rready)) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_ld_data;
            r_rresp  <= w_rgood ? 2'b00 : 2'b10;
            r_rlast  <= (r_rcnt == r_rlen);
            r_raddr  <= f_next(r_raddr, r_rlen, r_rburst);
            r_rcnt   <= r_rcnt + 8'd1;
            r_rst    <= R_DATA;
          end else if (r_rst == R_WAIT) begin
            r_lat <= r_lat - 4'd1;
          end
        end
        default: r_rst <= R_IDLE;
      endcase
    end
  end

  assign awready = r_awready;
  assign wready  = r_wready;
  assign bvalid  = r_bvalid;
  assign bid     = r_bid;
  assign bresp   = r_bresp;
  assign arready = r_arready;
  assign rvalid  = r_rvalid;
  assign rid     = r_rid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;
  assign rlast   = r_rlast;

endmodule

// File: tb/tb_mem_model_axi_burst.sv
// Directed bench for mem_model_axi_burst: 64-bit data, 1024 words,
// read latency 2.
module tb_mem_model_axi_burst;

  logic        aclk = 1'b0;
  logic        areset;
  logic [3:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready;
  logic        bvalid, bready, arvalid, arready;
  logic        rlast, rvalid, rready;
  logic [63:0] wdata, rdata;
  logic [7:0]  wstrb;

  int checks = 0;
  int errors = 0;

  logic [63:0] wd [16];
  logic [7:0]  ws [16];
  logic [63:0] rd [16];
  logic [1:0]  rr [16];
  logic        rl [16];
  logic [3:0]  rids [16];
  int          rlat;
  logic [2:0]  sz = 3'd3;

  mem_model_axi_burst #(
    .DATA_W(64), .ADDR_W(32), .ID_W(4),
    .DEPTH(1024), .READ_LATENCY(2)
  ) dut (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] a,
                         input logic [7:0] len, input logic [1:0] bt);
    int t; logic hs;
    awid = id; awaddr = a; awlen = len; awsize = sz; awburst = bt;
    awvalid = 1'b1; t = 0;
    do begin hs = awready; tick(); t++; end while (!hs && t < 100);
    awvalid = 1'b0;
    if (!hs) begin errors++; $display("FAIL aw_timeout"); end
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] s,
                        input logic l);
    int t; logic hs;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1; t = 0;
    do begin hs = wready; tick(); t++; end while (!hs && t < 100);
    wvalid = 1'b0; wlast = 1'b0;
    if (!hs) begin errors++; $display("FAIL w_timeout"); end
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [31:0] a,
                           input logic [7:0] len, input logic [1:0] bt,
                           input int last_at,
                           output logic [1:0] resp, output logic [3:0] ido);
    int t; logic hs;
    send_aw(id, a, len, bt);
    for (int b = 0; b <= int'(len); b++) send_w(wd[b], ws[b], b == last_at);
    bready = 1'b1; t = 0; resp = 2'bxx; ido = 4'hx;
    do begin
      hs = bvalid; resp = bresp; ido = bid; tick(); t++;
    end while (!hs && t < 100);
    bready = 1'b0;
    if (!hs) begin errors++; $display("FAIL b_timeout"); end
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] a,
                         input logic [7:0] len, input logic [1:0] bt);
    int t; logic hs;
    arid = id; araddr = a; arlen = len; arsize = sz; arburst = bt;
    arvalid = 1'b1; t = 0;
    do begin hs = arready; tick(); t++; end while (!hs && t < 100);
    arvalid = 1'b0;
    if (!hs) begin errors++; $display("FAIL ar_timeout"); end
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] a,
                          input logic [7:0] len, input logic [1:0] bt);
    int t, n, cyc; logic hs;
    send_ar(id, a, len, bt);
    rready = 1'b1; n = 0; t = 0; cyc = 0; rlat = -1;
    while (n <= int'(len) && t < 200) begin
      hs = rvalid;
      if (hs) begin
        rd[n] = rdata; rr[n] = rresp; rl[n] = rlast; rids[n] = rid;
        if (rlat < 0) rlat = cyc;
      end
      tick(); cyc++; t++;
      if (hs) n++;
    end
    rready = 1'b0;
    if (n <= int'(len)) begin errors++; $display("FAIL r_timeout n=%0d", n); end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    wlast = 0; wdata = 0; wstrb = 0; awid = 0; awaddr = 0; awlen = 0;
    awsize = 0; awburst = 0; arid = 0; araddr = 0; arlen = 0;
    arsize = 0; arburst = 0;
    repeat (3) tick();
    checks++;
    if ({awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata,
         rresp, rlast} !== '0) begin
      errors++; $display("FAIL reset_outputs awready=%b arready=%b rdata=%h",
                         awready, arready, rdata);
    end
    areset = 1'b0;
    checks++;
    if (awready !== 1'b0) begin
      errors++; $display("FAIL pre_edge_awready got %b want 0", awready);
    end
    tick();
    checks++;
    if (awready !== 1'b1 || arready !== 1'b1) begin
      errors++; $display("FAIL post_reset_ready aw=%b ar=%b want 1 1",
                         awready, arready);
    end
  endtask

  task automatic test_incr();
    logic [1:0] r; logic [3:0] i;
    for (int k = 0; k < 4; k++) begin wd[k] = 64'(8'h11 * (k + 1)); ws[k] = 8'hFF; end
    axi_write(4'h5, 32'h100, 8'd3, 2'd1, 3, r, i);
    checks++;
    if (r !== 2'b00 || i !== 4'h5) begin
      errors++; $display("FAIL incr_bresp got %0d/%h want 0/5", r, i);
    end
    axi_read(4'hA, 32'h100, 8'd3, 2'd1);
    checks++;
    if (rlat !== 3) begin
      errors++; $display("FAIL read_latency got %0d want 3", rlat);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rd[k] !== wd[k] || rr[k] !== 2'b00 || rl[k] !== (k == 3) ||
          rids[k] !== 4'hA) begin
        errors++;
        $display("FAIL incr_beat%0d got %h/%0d/%b/%h want %h/0/%b/a",
                 k, rd[k], rr[k], rl[k], rids[k], wd[k], k == 3);
      end
    end
  endtask

  task automatic test_strobe();
    logic [1:0] r; logic [3:0] i;
    wd[0] = 64'hFFFFFFFF_FFFFFFFF; ws[0] = 8'hFF;
    axi_write(4'h1, 32'h200, 8'd0, 2'd1, 0, r, i);
    wd[0] = 64'h0; ws[0] = 8'h0F;
    axi_write(4'h2, 32'h200, 8'd0, 2'd1, 0, r, i);
    axi_read(4'h3, 32'h200, 8'd0, 2'd1);
    checks++;
    if (rd[0] !== 64'hFFFFFFFF_00000000 || rl[0] !== 1'b1) begin
      errors++; $display("FAIL strobe got %h want ffffffff00000000", rd[0]);
    end
  endtask

  task automatic test_wrap();
    logic [1:0] r; logic [3:0] i;
    logic [63:0] exp4 [4];
    for (int k = 0; k < 4; k++) begin wd[k] = 64'(8'hA0 + k); ws[k] = 8'hFF; end
    axi_write(4'h6, 32'h0, 8'd3, 2'd1, 3, r, i);
    exp4[0] = 64'hA3; exp4[1] = 64'hA0; exp4[2] = 64'hA1; exp4[3] = 64'hA2;
    axi_read(4'h7, 32'h18, 8'd3, 2'd2);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rd[k] !== exp4[k] || rr[k] !== 2'b00 || rl[k] !== (k == 3)) begin
        errors++; $display("FAIL wrap_beat%0d got %h/%0d/%b want %h/0/%b",
                           k, rd[k], rr[k], rl[k], exp4[k], k == 3);
      end
    end
    axi_read(4'h8, 32'h0, 8'd2, 2'd2);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rd[k] !== 64'h0 || rr[k] !== 2'b10 || rl[k] !== (k == 2)) begin
        errors++; $display("FAIL wrap3_beat%0d got %h/%0d/%b want 0/2/%b",
                           k, rd[k], rr[k], rl[k], k == 2);
      end
    end
    axi_read(4'h9, 32'h8, 8'd2, 2'd0);
    checks++;
    if (rd[0] !== 64'hA1 || rd[1] !== 64'hA1 || rd[2] !== 64'hA1 ||
        rr[2] !== 2'b00) begin
      errors++; $display("FAIL fixed got %h %h %h want a1 x3", rd[0], rd[1], rd[2]);
    end
    sz = 3'd2;
    axi_read(4'h9, 32'h0, 8'd0, 2'd1);
    sz = 3'd3;
    checks++;
    if (rd[0] !== 64'h0 || rr[0] !== 2'b10) begin
      errors++; $display("FAIL bad_size got %h/%0d want 0/2", rd[0], rr[0]);
    end
  endtask

  task automatic test_oob();
    logic [1:0] r; logic [3:0] i;
    wd[0] = 64'hDEADBEEF; ws[0] = 8'hFF;
    axi_write(4'hB, 32'h2000, 8'd0, 2'd1, 0, r, i);
    checks++;
    if (r !== 2'b10) begin
      errors++; $display("FAIL oob_bresp got %0d want 2", r);
    end
    wd[0] = 64'h77; wd[1] = 64'h88; ws[0] = 8'hFF; ws[1] = 8'hFF;
    axi_write(4'hC, 32'h1FF8, 8'd1, 2'd1, 1, r, i);
    checks++;
    if (r !== 2'b10) begin
      errors++; $display("FAIL edge_bresp got %0d want 2", r);
    end
    axi_read(4'hD, 32'h1FF8, 8'd1, 2'd1);
    checks++;
    if (rd[0] !== 64'h77 || rr[0] !== 2'b00 || rd[1] !== 64'h0 ||
        rr[1] !== 2'b10 || rl[1] !== 1'b1) begin
      errors++; $display("FAIL edge_read got %h/%0d %h/%0d want 77/0 0/2",
                         rd[0], rr[0], rd[1], rr[1]);
    end
    axi_read(4'hD, 32'h0, 8'd0, 2'd1);
    checks++;
    if (rd[0] !== 64'hA0 || rr[0] !== 2'b00) begin
      errors++; $display("FAIL oob_alias got %h want a0", rd[0]);
    end
  endtask

  task automatic test_early_wlast();
    logic [1:0] r; logic [3:0] i;
    for (int k = 0; k < 4; k++) begin wd[k] = 64'(8'hB1 + k); ws[k] = 8'hFF; end
    axi_write(4'h4, 32'h300, 8'd3, 2'd1, 1, r, i);
    checks++;
    if (r !== 2'b10 || i !== 4'h4) begin
      errors++; $display("FAIL early_wlast_bresp got %0d want 2", r);
    end
    axi_read(4'h4, 32'h300, 8'd3, 2'd1);
    checks++;
    if (rd[0] !== 64'hB1 || rd[1] !== 64'hB2 || rd[2] !== 64'hB3 ||
        rd[3] !== 64'hB4) begin
      errors++; $display("FAIL early_wlast_data got %h %h %h %h",
                         rd[0], rd[1], rd[2], rd[3]);
    end
  endtask

  task automatic test_stall();
    int t; int bad; int n;
    send_ar(4'h2, 32'h100, 8'd3, 2'd1);
    rready = 1'b1; t = 0;
    while (rvalid !== 1'b1 && t < 50) begin tick(); t++; end
    tick();
    rready = 1'b0;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (rvalid !== 1'b1 || rdata !== 64'h22 || rlast !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL r_stall got rvalid=%b rdata=%h rlast=%b want 1/22/0",
                         rvalid, rdata, rlast);
    end
    rready = 1'b1; n = 0; t = 0;
    while (n < 3 && t < 50) begin
      if (rvalid === 1'b1) begin
        n++;
        if (n == 3) begin
          checks++;
          if (rdata !== 64'h44 || rlast !== 1'b1) begin
            errors++; $display("FAIL stall_last got %h/%b want 44/1", rdata, rlast);
          end
        end
      end
      tick(); t++;
    end
    rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      errors++; $display("FAIL r_done got rvalid=%b arready=%b want 0 1",
                         rvalid, arready);
    end
  endtask

  task automatic test_bready_hold();
    int t; int bad;
    send_aw(4'h9, 32'h208, 8'd0, 2'd1);
    send_w(64'h5A5A, 8'hFF, 1'b1);
    t = 0;
    while (bvalid !== 1'b1 && t < 20) begin tick(); t++; end
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (bvalid !== 1'b1 || awready !== 1'b0 || bresp !== 2'b00 ||
          bid !== 4'h9) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL b_hold got bvalid=%b awready=%b want 1 0",
                         bvalid, awready);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1) begin
      errors++; $display("FAIL b_done got bvalid=%b awready=%b want 0 1",
                         bvalid, awready);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] r; logic [3:0] i;
    for (int k = 0; k < 4; k++) begin wd[k] = 64'(8'h51 + k); ws[k] = 8'hFF; end
    axi_write(4'h1, 32'h400, 8'd3, 2'd1, 3, r, i);
    send_aw(4'h2, 32'h400, 8'd3, 2'd1);
    send_w(64'hE1, 8'hFF, 1'b0);
    send_w(64'hE2, 8'hFF, 1'b0);
    wdata = 64'hE3; wstrb = 8'hFF; wvalid = 1'b1;
    areset = 1'b1;
    #1;
    checks++;
    if ({awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata,
         rresp, rlast} !== '0) begin
      errors++; $display("FAIL mid_reset_outputs wready=%b awready=%b",
                         wready, awready);
    end
    tick();
    wdata = 64'hE4;
    tick();
    wvalid = 1'b0;
    areset = 1'b0;
    tick();
    checks++;
    if (awready !== 1'b1 || arready !== 1'b1) begin
      errors++; $display("FAIL mid_reset_release aw=%b ar=%b want 1 1",
                         awready, arready);
    end
    axi_read(4'h3, 32'h400, 8'd3, 2'd1);
    checks++;
    if (rd[0] !== 64'hE1 || rd[1] !== 64'hE2 || rd[2] !== 64'h53 ||
        rd[3] !== 64'h54) begin
      errors++; $display("FAIL mid_reset_mem got %h %h %h %h want e1 e2 53 54",
                         rd[0], rd[1], rd[2], rd[3]);
    end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_strobe();
    test_wrap();
    test_oob();
    test_early_wlast();
    test_stall();
    test_bready_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
